burst_main_memory: RTL

Parametrised word-addressed backing memory that serves the BDI cache hierarchy. It adds four capabilities: valid/ready request and response channels, byte-enable writes, a programmable read latency, and line-fill bursts that return the critical word first and wrap within the line. It sits behind the cache miss/fill logic. It returns one uncompressed line per fill request for the compressor to consume.

---
 rtl/main_memory_pkg.sv | 30 +++
 rtl/mem_bank_sram.sv | 30 +++
 rtl/burst_main_memory.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/main_memory_pkg.sv
// Shared types and width helpers for the burst main memory and its storage bank.
package main_memory_pkg;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_STREAM} mem_state_e;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;

    function automatic int be_width(input int word_width);
        return word_width / 8;
    endfunction

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // One extra bit so the beat index can reach LINE_WORDS itself.
    function automatic int cnt_w(input int line_words);
        return $clog2(line_words) + 1;
    endfunction

    typedef struct packed {
        logic                            write;
        logic                            burst;
        logic [DEF_ADDR_WIDTH-3:0]       addr;
        logic [DEF_WORD_WIDTH-1:0]       wdata;
        logic [DEF_WORD_WIDTH/8-1:0]     be;
    } req_t;

endpackage

// File: rtl/mem_bank_sram.sv
// Single-port synchronous word RAM with per-byte write enable and a registered read port.
module mem_bank_sram
    import main_memory_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH_LOG2 = 20,
    localparam int BE_WIDTH  = be_width(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // rdata only changes on a read, so it holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (en) rdata <= mem[addr];
    end

endmodule

// File: rtl/burst_main_memory.sv
// Backing memory with valid/ready channels, byte-enable writes, programmable read
// latency and critical-word-first wrapping line bursts.
module burst_main_memory
    import main_memory_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 20,
    parameter int LINE_WORDS   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_burst,
    input  logic [ADDR_WIDTH-3:0]   req_addr,
    input  logic [WORD_WIDTH-1:0]   req_wdata,
    input  logic [WORD_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WORD_WIDTH-1:0]   rsp_data,
    output logic                    rsp_last
);

    localparam int BE_WIDTH = be_width(WORD_WIDTH);
    localparam int OFF_W    = off_w(LINE_WORDS);
    localparam int CNT_W    = cnt_w(LINE_WORDS);
    localparam int LAT_W    = $clog2(READ_LATENCY + 1);
    localparam int BASE_W   = DEPTH_LOG2 - OFF_W;

    mem_state_e            state, state_nxt;
    logic [LAT_W-1:0]      lat_cnt, lat_cnt_nxt;
    logic [CNT_W-1:0]      iss_k, iss_k_nxt, issue_k, last_k_q, last_k_cur;
    logic [BASE_W-1:0]     base_q;
    logic [OFF_W-1:0]      off_q, wrap_off;
    logic                  accept, adv, issue, issue_last, sram_we;
    logic [DEPTH_LOG2-1:0] sram_addr;
    logic [WORD_WIDTH-1:0] rdata_p1;
    logic                  vld_p1, last_p1;
    logic                  unused_addr_hi;

    assign accept     = req_valid && req_ready;
    assign adv        = !rsp_valid || rsp_ready;
    assign wrap_off   = off_q + iss_k[OFF_W-1:0];
    assign last_k_cur = (state == IDLE) ? (req_burst ? CNT_W'(LINE_WORDS - 1) : '0) : last_k_q;
    assign issue_last = issue && (issue_k == last_k_cur);
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-3:DEPTH_LOG2];

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        iss_k_nxt   = iss_k;
        issue       = 1'b0;
        issue_k     = '0;
        sram_we     = 1'b0;
        sram_addr   = req_addr[DEPTH_LOG2-1:0];
        case (state)
            IDLE: begin
                if (accept && req_write) begin
                    sram_we = 1'b1;
                end else if (accept) begin
                    if (READ_LATENCY == 1) begin
                        issue     = 1'b1;
                        iss_k_nxt = CNT_W'(1);
                        state_nxt = RD_STREAM;
                    end else begin
                        lat_cnt_nxt = LAT_W'(READ_LATENCY - 1);
                        state_nxt   = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                sram_addr = {base_q, off_q};
                if (lat_cnt == LAT_W'(1)) begin
                    issue     = 1'b1;
                    iss_k_nxt = CNT_W'(1);
                    state_nxt = RD_STREAM;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end
            RD_STREAM: begin
                sram_addr = {base_q, wrap_off};
                issue_k   = iss_k;
                if (adv && (iss_k <= last_k_q)) begin
                    issue     = 1'b1;
                    iss_k_nxt = iss_k + CNT_W'(1);
                end
                if (rsp_valid && rsp_ready && rsp_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            iss_k     <= '0;
            req_ready <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            iss_k     <= iss_k_nxt;
            req_ready <= (state_nxt == IDLE);
            // p1: SRAM read in flight -> p2: response register; whole pipe stalls together
            if (adv) begin
                vld_p1    <= issue;
                last_p1   <= issue_last;
                rsp_valid <= vld_p1;
                rsp_last  <= last_p1;
                if (vld_p1) rsp_data <= rdata_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !req_write) begin
            base_q   <= req_addr[DEPTH_LOG2-1:OFF_W];
            off_q    <= req_addr[OFF_W-1:0];
            last_k_q <= req_burst ? CNT_W'(LINE_WORDS - 1) : '0;
        end
    end

    mem_bank_sram #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk   (clk),
        .en    (issue),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (req_wdata),
        .be    (req_be[BE_WIDTH-1:0]),
        .rdata (rdata_p1)
    );

endmodule
